// File: rtl/vsram_mb.sv
// Multi-bank Q-vector staging SRAM: round-robin fill/read banks with partial-tile
// close (write_last) and multi-pass reuse of each tile before its bank is released.
module vsram_mb #(
    parameter  int NUM_ROWS  = 8,
    parameter  int NUM_BANKS = 2,
    parameter  int ELEM_W    = 8,
    parameter  int VEC_LEN   = 64,
    parameter  int PASS_W    = 8,
    localparam int VEC_W     = ELEM_W * VEC_LEN,
    localparam int ROW_W     = $clog2(NUM_ROWS + 1),
    localparam int BF_W      = $clog2(NUM_BANKS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_enable,
    input  logic [VEC_W-1:0]          write_data,
    input  logic                      write_last,
    input  logic [PASS_W-1:0]         cfg_passes,
    output logic                      sram_ready,
    input  logic                      read_enable,
    output logic                      read_data_valid,
    output logic [NUM_ROWS*VEC_W-1:0] read_data,
    output logic [ROW_W-1:0]          read_rows,
    output logic                      read_last,
    output logic [BF_W-1:0]           banks_full,
    output logic [2*NUM_BANKS-1:0]    dbg_bank_state_o
);

    localparam int IDX_W = $clog2(NUM_ROWS);
    localparam int PTR_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    bank_state_e       state_q  [NUM_BANKS];
    bank_state_e       state_d  [NUM_BANKS];
    logic [ROW_W-1:0]  rows_q   [NUM_BANKS];
    logic [ROW_W-1:0]  rows_d   [NUM_BANKS];
    logic [PASS_W-1:0] passes_q [NUM_BANKS];
    logic [PASS_W-1:0] passes_d [NUM_BANKS];
    logic [VEC_W-1:0]  mem_q    [NUM_BANKS][NUM_ROWS];

    logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

    logic wr_acc, wr_close, rd_acc, rd_rel;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes: a row moves when write_enable && sram_ready at a rising edge; a pass
    // is consumed when read_enable && read_data_valid. Both readies come from registered
    // bank state only, so a release frees its bank for writing one cycle later.
    assign sram_ready      = (state_q[fill_ptr_q] != BANK_FULL);
    assign read_data_valid = (state_q[rd_ptr_q] == BANK_FULL);
    assign wr_acc          = write_enable && sram_ready;
    assign wr_close        = wr_acc && ((wr_idx_q == IDX_W'(NUM_ROWS - 1)) || write_last);
    assign rd_acc          = read_enable && read_data_valid;
    assign rd_rel          = rd_acc && (passes_q[rd_ptr_q] == PASS_W'(1));

    assign read_rows = read_data_valid ? rows_q[rd_ptr_q] : '0;
    assign read_last = read_data_valid && (passes_q[rd_ptr_q] == PASS_W'(1));

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        passes_d   = passes_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_idx_d   = wr_idx_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_acc && (fill_ptr_q == PTR_W'(b))) begin
                state_d[b] = wr_close ? BANK_FULL : BANK_FILLING;
                if (wr_idx_q == '0) begin
                    passes_d[b] = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                end
                if (wr_close) begin
                    rows_d[b] = ROW_W'(wr_idx_q) + ROW_W'(1);
                end
            end
            // The read bank is always FULL, so it can never be the bank being written.
            if (rd_acc && (rd_ptr_q == PTR_W'(b))) begin
                if (rd_rel) begin
                    state_d[b] = BANK_EMPTY;
                end else begin
                    passes_d[b] = passes_q[b] - PASS_W'(1);
                end
            end
        end
        if (wr_acc) begin
            wr_idx_d = wr_close ? '0 : wr_idx_q + IDX_W'(1);
            if (wr_close) begin
                fill_ptr_d = next_ptr(fill_ptr_q);
            end
        end
        if (rd_rel) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b]  <= BANK_EMPTY;
                rows_q[b]   <= '0;
                passes_q[b] <= '0;
            end
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            passes_q   <= passes_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    // Row storage is not reset; stale rows are masked on the read side.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[fill_ptr_q][wr_idx_q] <= write_data;
        end
    end

    always_comb begin
        read_data = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (read_data_valid && (ROW_W'(r) < read_rows)) begin
                read_data[r*VEC_W +: VEC_W] = mem_q[rd_ptr_q][r];
            end
        end
    end

    always_comb begin
        banks_full       = '0;
        dbg_bank_state_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q[b] == BANK_FULL) begin
                banks_full = banks_full + BF_W'(1);
            end
            dbg_bank_state_o[2*b +: 2] = state_q[b];
        end
    end

endmodule

// File: tb/tb_vsram_mb.sv
// Bench for vsram_mb: tile-level reference model feeding an expected-pass queue,
// checked every cycle by an independent monitor.
`timescale 1ns/1ps
module tb_vsram_mb;

  localparam int NR     = 8;
  localparam int NB     = 2;
  localparam int EL_W   = 8;
  localparam int VL     = 8;
  localparam int PW     = 8;
  localparam int VEC_W  = EL_W * VL;
  localparam int DW     = NR * VEC_W;
  localparam int ROW_W  = $clog2(NR + 1);
  localparam int BF_W   = $clog2(NB + 1);
  localparam int ENT_W  = 1 + ROW_W + DW;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              write_enable;
  logic [VEC_W-1:0]  write_data;
  logic              write_last;
  logic [PW-1:0]     cfg_passes;
  logic              sram_ready;
  logic              read_enable;
  logic              read_data_valid;
  logic [DW-1:0]     read_data;
  logic [ROW_W-1:0]  read_rows;
  logic              read_last;
  logic [BF_W-1:0]   banks_full;
  logic [2*NB-1:0]   dbg_bank_state;

  always #5 clk = ~clk;

  vsram_mb #(
    .NUM_ROWS(NR), .NUM_BANKS(NB), .ELEM_W(EL_W), .VEC_LEN(VL), .PASS_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .write_data(write_data), .write_last(write_last),
    .cfg_passes(cfg_passes), .sram_ready(sram_ready),
    .read_enable(read_enable), .read_data_valid(read_data_valid),
    .read_data(read_data), .read_rows(read_rows), .read_last(read_last),
    .banks_full(banks_full), .dbg_bank_state_o(dbg_bank_state)
  );

  // ---------------- reference model ----------------
  // Stored tiles form a FIFO; each tile contributes one queue entry per pass:
  // {is_final_pass, row_count, zero-padded tile image}.
  logic [ENT_W-1:0] exp_q[$];
  int               m_full;
  int               m_idx;
  int               cur_passes;
  logic [DW-1:0]    cur_tile;
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VEC_W-1:0] rnd_row();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks (called and return at negedge) ----------------
  task automatic cycle(input logic we, input logic [VEC_W-1:0] wd, input logic wl,
                       input logic [PW-1:0] cfg, input logic re, output logic w_acc);
    logic r_rel;
    write_enable = we;
    write_data   = wd;
    write_last   = wl;
    cfg_passes   = cfg;
    read_enable  = re;
    w_acc = we && (m_full < NB);
    r_rel = 1'b0;
    if (re && m_full > 0 && exp_q.size() > 0) r_rel = exp_q[0][ENT_W-1];
    @(posedge clk);
    #1;
    if (w_acc) begin
      if (m_idx == 0) begin
        cur_tile   = '0;
        cur_passes = (cfg == 0) ? 1 : int'(cfg);
      end
      cur_tile[m_idx*VEC_W +: VEC_W] = wd;
      if (m_idx == NR - 1 || wl) begin
        for (int p = 0; p < cur_passes; p++)
          exp_q.push_back({(p == cur_passes - 1), ROW_W'(m_idx + 1), cur_tile});
        m_full++;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (r_rel) m_full--;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) cycle(1'b0, '0, 1'b0, '0, 1'b0, a);
  endtask

  task automatic put_row(input logic [VEC_W-1:0] d, input logic wl, input logic [PW-1:0] cfg);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cycle(1'b1, d, wl, cfg, 1'b0, acc);
      tries++;
    end
    if (!acc) chk("row_accept_timeout", DW'(acc), DW'(1));
  endtask

  task automatic put_tile(input int n, input logic [PW-1:0] cfg, input logic idx_data);
    for (int r = 0; r < n; r++)
      put_row(idx_data ? VEC_W'(r) : rnd_row(), (r == n - 1) && (n < NR), cfg);
  endtask

  task automatic drain();
    logic a;
    int   g;
    g = 0;
    while (m_full > 0 && g < 64) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b1, a);
      g++;
    end
    if (m_full > 0) chk("drain_timeout", DW'(m_full), DW'(0));
    idle(1);
  endtask

  task automatic do_reset();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    #1 rst = 1'b0;
    exp_q.delete();
    m_full = 0;
    m_idx  = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [ENT_W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      chk("sram_ready", DW'(sram_ready), DW'(m_full < NB));
      chk("banks_full", DW'(banks_full), DW'(m_full));
      chk("read_data_valid", DW'(read_data_valid), DW'(m_full > 0));
      if (m_full > 0 && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("read_rows", DW'(read_rows), DW'(e[DW +: ROW_W]));
        chk("read_last", DW'(read_last), DW'(e[ENT_W-1]));
        chk("read_data", read_data, e[DW-1:0]);
        if (read_enable) void'(exp_q.pop_front());
      end else begin
        chk("idle_read_rows", DW'(read_rows), '0);
        chk("idle_read_last", DW'(read_last), '0);
        chk("idle_read_data", read_data, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic             a;
    logic [VEC_W-1:0] d;
    rst = 1'b0;
    write_enable = 1'b0; write_data = '0; write_last = 1'b0;
    cfg_passes = '0; read_enable = 1'b0;
    m_full = 0; m_idx = 0; cur_passes = 1; cur_tile = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Full tile of row-index data, single pass.
    put_tile(NR, 8'd1, 1'b1);
    idle(2);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, a);
    idle(2);

    // Overfill: third tile's first row waits, then lands one cycle after a release.
    put_tile(NR, 8'd1, 1'b0);
    put_tile(NR, 8'd1, 1'b0);
    d = rnd_row();
    repeat (3) cycle(1'b1, d, 1'b0, 8'd1, 1'b0, a);
    cycle(1'b1, d, 1'b0, 8'd1, 1'b1, a);
    put_row(d, 1'b0, 8'd1);
    for (int r = 1; r < NR; r++) put_row(rnd_row(), 1'b0, 8'd1);
    drain();

    // Partial tile closed on row 3, then a full tile that must start at row 0.
    put_tile(3, 8'd1, 1'b0);
    put_tile(NR, 8'd1, 1'b1);
    drain();

    // Multi-pass reuse, with idle gaps between passes, then cfg_passes = 0.
    put_tile(NR, 8'd3, 1'b0);
    repeat (3) begin
      idle(1);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, a);
    end
    idle(1);
    put_tile(5, 8'd0, 1'b0);
    drain();

    // Producer blocked on the read bank while it finishes its last of two passes.
    put_tile(NR, 8'd2, 1'b0);
    put_tile(NR, 8'd1, 1'b0);
    d = rnd_row();
    cycle(1'b1, d, 1'b0, 8'd1, 1'b1, a);
    cycle(1'b1, d, 1'b0, 8'd1, 1'b1, a);
    put_row(d, 1'b0, 8'd1);
    for (int r = 1; r < NR; r++) put_row(rnd_row(), 1'b0, 8'd1);
    drain();

    // Reset with one tile pending and the next tile filled up to row 4.
    put_tile(NR, 8'd1, 1'b0);
    for (int r = 0; r < 5; r++) put_row(rnd_row(), 1'b0, 8'd1);
    do_reset();
    idle(1);
    put_tile(NR, 8'd2, 1'b0);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_row(), $urandom_range(0, 5) == 0,
            PW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, a);
    end
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vsram_mb.md
Name: vsram_mb

Overview:
- Parametrised successor to the double-buffered Q-vector staging SRAM. Sits between the memory controller and the backend PE array.
- Generalises ping-pong to NUM_BANKS round-robin banks with configurable row and vector geometry.
- Adds partial-tile termination (write_last) and multi-pass reuse: one Q tile is held and re-presented across several K/V blocks before its bank is released.

Parameters:
- NUM_ROWS, 8, rows per bank (one per PE); ≥2.
- NUM_BANKS, 2, bank count; ≥2.
- ELEM_W, 8, bits per vector element.
- VEC_LEN, 64, elements per row; VEC_W = ELEM_W*VEC_LEN.
- PASS_W, 8, width of the reuse-pass count.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset (asserted at 0).
- write_enable, input, 1, producer presents a row.
- write_data, input, VEC_W, row payload.
- write_last, input, 1, this row ends the tile (qualified by write_enable).
- cfg_passes, input, PASS_W, reads before release; sampled on the first row of a tile.
- sram_ready, output, 1, fill bank can accept a row.
- read_enable, input, 1, backend consumes one pass of the read bank.
- read_data_valid, output, 1, read bank holds a complete tile.
- read_data, output, NUM_ROWS*VEC_W, all rows of the read bank; row r at bits [r*VEC_W +: VEC_W].
- read_rows, output, $clog2(NUM_ROWS+1), valid row count of the presented tile.
- read_last, output, 1, the current pass is the final one for this tile.
- banks_full, output, $clog2(NUM_BANKS+1), number of FULL banks.

Behaviour:
- Per-bank state: EMPTY → FILLING (first row accepted) → FULL (last row accepted) → EMPTY (final pass consumed).
- Per-bank registers: row storage, row count, pass count.
- fill_ptr and rd_ptr each advance round-robin, wrapping NUM_BANKS-1 → 0.
- Reset (rst=0, async):
  - All banks EMPTY; fill_ptr = rd_ptr = wr_idx = 0.
  - sram_ready = 1; read_data_valid = 0; read_rows = 0; read_last = 0; banks_full = 0; read_data = 0.
  - Row storage contents need not be cleared.
- sram_ready is combinational: high when bank[fill_ptr] is not FULL.
- Write accept: write_enable && sram_ready.
  - Stores write_data into row wr_idx of bank[fill_ptr].
  - If wr_idx == 0: latches cfg_passes into the bank's pass count; 0 is stored as 1.
- Tile close: wr_idx == NUM_ROWS-1, or write_last, on an accepted row.
  - Bank row count = wr_idx+1; bank → FULL.
  - wr_idx → 0; fill_ptr advances.
  - Otherwise wr_idx increments.
- write_enable while sram_ready = 0: ignored; no state change. The producer must hold data.
- read_data_valid is high when bank[rd_ptr] is FULL.
  - read_rows = that bank's row count.
  - read_last = (pass count == 1).
  - read_data is combinational from bank[rd_ptr]; rows ≥ read_rows are driven 0.
  - When not valid, read_data = 0 and read_rows = 0.
- Read accept: read_enable && read_data_valid.
  - Pass count > 1: decrement it; bank remains presented unchanged.
  - Pass count == 1: bank → EMPTY; rd_ptr advances.
- read_enable while not valid: ignored.
- Latency:
  - Write to read_data_valid: 1 cycle after the closing row's edge.
  - Release to sram_ready: 1 cycle.
- Simultaneous events:
  - Write and read in the same cycle are independent.
  - If the fill bank equals the read bank being released, sram_ready stays 0 that cycle. The row is accepted the next cycle (no bypass).
- All banks FULL: sram_ready = 0, banks_full = NUM_BANKS.
- A bank is never read while FILLING. rd_ptr never passes fill_ptr.
- Reset mid-tile: a partial fill is discarded; the next accepted row goes to bank 0, row 0.
- banks_full is combinational from the bank states.

Test Plan:
- Reset, then 8 rows (value = row idx), cfg_passes = 1 → read_data_valid 1 cycle after the 8th row; read_rows = 8; read_last = 1. After one read_enable, valid drops and banks_full = 0.
- NUM_BANKS = 2: write 3 full tiles with no reads → sram_ready = 0 after the 16th row; banks_full = 2; the 17th row is ignored. One read accepts it the next cycle.
- write_last on the 3rd row → read_rows = 3; rows 3–7 of read_data = 0; the next tile starts in bank 1 at row 0.
- cfg_passes = 3 → read_last = 0, 0, 1 across three read_enables; data is stable for all passes; the bank is freed only after the 3rd. cfg_passes = 0 behaves as 1.
- Release the read bank while the producer waits on the same bank → the row is accepted exactly one cycle later and its data is correct.
- Assert rst mid-fill (row 5) with a full bank pending → all outputs return to reset values asynchronously; subsequent tile data is correct from bank 0.
